// File: rtl/recirculador_fifo.sv
// recirculador_fifo: per-lane FIFOs that recirculate traffic toward the L1 mux, plus a one-cycle bypass toward the probe path
module recirculador_fifo #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      active,
    input  logic [LANES*DATA_W-1:0]   data_in,
    input  logic [LANES-1:0]          valid_in,
    input  logic [LANES-1:0]          pause_l1,
    output logic [LANES*DATA_W-1:0]   data_activo,
    output logic [LANES-1:0]          valid_activo,
    output logic [LANES*DATA_W-1:0]   data_desactivado,
    output logic [LANES-1:0]          valid_desactivado,
    output logic [LANES-1:0]          fifo_full,
    output logic [LANES-1:0]          fifo_empty,
    output logic [LANES-1:0]          overflow,
    output logic                      draining
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {PASS, ACTIVE, DRAIN} state_t;

    state_t                  r_state, w_next;
    logic [DATA_W-1:0]       r_mem [LANES][DEPTH];
    logic [AW-1:0]           r_wptr [LANES];
    logic [AW-1:0]           r_rptr [LANES];
    logic [AW:0]             r_cnt [LANES];
    logic [AW:0]             w_cnt_nx [LANES];
    logic [LANES-1:0]        w_push, w_pop, w_drop, w_nonempty_nx;
    logic [LANES*DATA_W-1:0] r_data_activo, r_data_des;
    logic [LANES-1:0]        r_valid_activo, r_valid_des, r_full, r_empty, r_overflow;

    // per-lane push/pop/drop decisions and the occupancy each lane will have after this edge
    always_comb begin
        w_push        = '0;
        w_pop         = '0;
        w_drop        = '0;
        w_nonempty_nx = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop[i]         = (r_cnt[i] != '0) && !pause_l1[i];
            w_push[i]        = active && valid_in[i] && ((r_cnt[i] != FULL_CNT) || w_pop[i]);
            w_drop[i]        = active && valid_in[i] && (r_cnt[i] == FULL_CNT) && !w_pop[i];
            w_cnt_nx[i]      = r_cnt[i] + (AW+1)'(w_push[i]) - (AW+1)'(w_pop[i]);
            w_nonempty_nx[i] = (w_cnt_nx[i] != '0);
        end
    end

    // FIFO storage writes; a full lane that pops frees the slot the write pointer now targets
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (reset && w_push[i])
                r_mem[i][r_wptr[i]] <= data_in[i*DATA_W +: DATA_W];
    end

    // pointers, counts, status flags and both registered output paths
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_data_activo  <= '0;
            r_data_des     <= '0;
            r_valid_activo <= '0;
            r_valid_des    <= '0;
            r_full         <= '0;
            r_empty        <= '1;
            r_overflow     <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                r_cnt[i]          <= w_cnt_nx[i];
                r_full[i]         <= (w_cnt_nx[i] == FULL_CNT);
                r_empty[i]        <= (w_cnt_nx[i] == '0);
                r_valid_activo[i] <= w_pop[i];
                r_valid_des[i]    <= !active && valid_in[i];
                if (w_drop[i])
                    r_overflow[i] <= 1'b1;
                if (w_push[i])
                    r_wptr[i] <= r_wptr[i] + AW'(1);
                if (w_pop[i]) begin
                    r_rptr[i]                          <= r_rptr[i] + AW'(1);
                    r_data_activo[i*DATA_W +: DATA_W]  <= r_mem[i][r_rptr[i]];
                end
                if (!active && valid_in[i])
                    r_data_des[i*DATA_W +: DATA_W] <= data_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= PASS;
        else
            r_state <= w_next;
    end

    // next state; emptiness is judged after this edge's pops so a lone word leaving does not enter DRAIN
    always_comb begin
        w_next = r_state;
        case (r_state)
            PASS:    w_next = active ? ACTIVE : PASS;
            ACTIVE:  w_next = active ? ACTIVE : (|w_nonempty_nx ? DRAIN : PASS);
            DRAIN:   w_next = active ? ACTIVE : (|w_nonempty_nx ? DRAIN : PASS);
            default: w_next = PASS;
        endcase
    end

    assign data_activo       = r_data_activo;
    assign valid_activo      = r_valid_activo;
    assign data_desactivado  = r_data_des;
    assign valid_desactivado = r_valid_des;
    assign fifo_full         = r_full;
    assign fifo_empty        = r_empty;
    assign overflow          = r_overflow;
    assign draining          = (r_state == DRAIN);
endmodule

// File: tb/tb_recirculador_fifo.sv
// tb_recirculador_fifo: directed vectors with hand-computed expectations for recirculador_fifo
module tb_recirculador_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic        active;
    logic [31:0] data_in;
    logic [3:0]  valid_in;
    logic [3:0]  pause_l1;
    logic [31:0] data_activo, data_desactivado;
    logic [3:0]  valid_activo, valid_desactivado, fifo_full, fifo_empty, overflow;
    logic        draining;
    int          errs = 0;
    int          checks = 0;

    recirculador_fifo dut (
        .clk(clk), .reset(reset), .active(active), .data_in(data_in),
        .valid_in(valid_in), .pause_l1(pause_l1),
        .data_activo(data_activo), .valid_activo(valid_activo),
        .data_desactivado(data_desactivado), .valid_desactivado(valid_desactivado),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow), .draining(draining)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"}, 32'(fifo_empty), 32'hF);
        check({tag, "_full"}, 32'(fifo_full), 32'h0);
        check({tag, "_ovf"}, 32'(overflow), 32'h0);
        check({tag, "_va"}, 32'(valid_activo), 32'h0);
        check({tag, "_vd"}, 32'(valid_desactivado), 32'h0);
        check({tag, "_da"}, data_activo, 32'h0);
        check({tag, "_dd"}, data_desactivado, 32'h0);
        check({tag, "_drain"}, 32'(draining), 32'h0);
    endtask

    initial begin
        reset = 1'b0; active = 1'b0; data_in = '0; valid_in = '0; pause_l1 = '0;
        step();
        step();
        check_reset_state("rst");
        reset = 1'b1;

        // bypass path, one-cycle latency
        active = 1'b0; valid_in = 4'hF; data_in = 32'h4E0E0E00;
        step();
        check("byp_data", data_desactivado, 32'h4E0E0E00);
        check("byp_valid", 32'(valid_desactivado), 32'hF);
        check("byp_va", 32'(valid_activo), 32'h0);
        valid_in = 4'h0; data_in = 32'h12345678;
        step();
        check("byp_idle_valid", 32'(valid_desactivado), 32'h0);
        check("byp_hold", data_desactivado, 32'h4E0E0E00);

        // single word through the active path
        active = 1'b1; valid_in = 4'h1; data_in = 32'h000000C0;
        step();
        check("act_empty_k", 32'(fifo_empty), 32'hE);
        check("act_va_k", 32'(valid_activo), 32'h0);
        check("act_drain_k", 32'(draining), 32'h0);
        active = 1'b0; valid_in = 4'h0;
        step();
        check("act_data_k1", data_activo, 32'h000000C0);
        check("act_va_k1", 32'(valid_activo), 32'h1);
        check("act_drain_k1", 32'(draining), 32'h0);
        check("act_empty_k1", 32'(fifo_empty), 32'hF);
        step();
        check("act_va_idle", 32'(valid_activo), 32'h0);
        check("act_hold", data_activo, 32'h000000C0);

        // lane 1 fills under pause, fifth word dropped
        active = 1'b1; pause_l1 = 4'h2; valid_in = 4'h2;
        for (int j = 1; j <= 5; j++) begin
            data_in = 32'(j) << 8;
            step();
            if (j == 3) check("ovf_full3", 32'(fifo_full), 32'h0);
            if (j == 4) begin
                check("ovf_full4", 32'(fifo_full), 32'h2);
                check("ovf_none4", 32'(overflow), 32'h0);
            end
        end
        check("ovf_full5", 32'(fifo_full), 32'h2);
        check("ovf_set", 32'(overflow), 32'h2);
        valid_in = 4'h0; pause_l1 = 4'h0;
        for (int j = 1; j <= 4; j++) begin
            step();
            check("ovf_order", 32'(data_activo[15:8]), 32'(j));
            check("ovf_va", 32'(valid_activo), 32'h2);
        end
        step();
        check("ovf_done_va", 32'(valid_activo), 32'h0);
        check("ovf_done_empty", 32'(fifo_empty), 32'hF);
        check("ovf_sticky", 32'(overflow), 32'h2);
        active = 1'b0;
        step();

        // drain lane 2 while new traffic bypasses
        active = 1'b1; pause_l1 = 4'h4; valid_in = 4'h4;
        for (int j = 1; j <= 3; j++) begin
            data_in = 32'(8'hA0 + j) << 16;
            step();
        end
        check("drn_empty", 32'(fifo_empty), 32'hB);
        active = 1'b0; pause_l1 = 4'h0; valid_in = 4'h1; data_in = 32'h00000055;
        step();
        check("drn_d1", 32'(draining), 32'h1);
        check("drn_a1", 32'(data_activo[23:16]), 32'hA1);
        check("drn_va1", 32'(valid_activo), 32'h4);
        check("drn_byp1", 32'(data_desactivado[7:0]), 32'h55);
        check("drn_vd1", 32'(valid_desactivado), 32'h1);
        data_in = 32'h00000066;
        step();
        check("drn_d2", 32'(draining), 32'h1);
        check("drn_a2", 32'(data_activo[23:16]), 32'hA2);
        check("drn_byp2", 32'(data_desactivado[7:0]), 32'h66);
        valid_in = 4'h0;
        step();
        check("drn_a3", 32'(data_activo[23:16]), 32'hA3);
        check("drn_va3", 32'(valid_activo), 32'h4);
        check("drn_d3", 32'(draining), 32'h0);
        check("drn_empty3", 32'(fifo_empty), 32'hF);

        // full lane 3 with simultaneous push and pop
        active = 1'b1; pause_l1 = 4'h8; valid_in = 4'h8;
        for (int j = 1; j <= 4; j++) begin
            data_in = 32'(8'hB0 + j) << 24;
            step();
        end
        check("fp_full", 32'(fifo_full), 32'h8);
        pause_l1 = 4'h0;
        for (int j = 5; j <= 6; j++) begin
            data_in = 32'(8'hB0 + j) << 24;
            step();
            check("fp_data", 32'(data_activo[31:24]), 32'(8'hB0 + j - 4));
            check("fp_full_kept", 32'(fifo_full), 32'h8);
            check("fp_no_ovf", 32'(overflow), 32'h2);
        end
        valid_in = 4'h0;
        for (int j = 3; j <= 6; j++) begin
            step();
            check("fp_order", 32'(data_activo[31:24]), 32'(8'hB0 + j));
        end
        check("fp_empty", 32'(fifo_empty), 32'hF);
        active = 1'b0;
        step();

        // reset while lanes 0 and 1 are half full
        active = 1'b1; pause_l1 = 4'h3; valid_in = 4'h3;
        data_in = 32'h00002211;
        step();
        data_in = 32'h00004433;
        step();
        check("mid_empty", 32'(fifo_empty), 32'hC);
        reset = 1'b0;
        step();
        check_reset_state("mid");
        reset = 1'b1; active = 1'b0; pause_l1 = 4'h0; valid_in = 4'h0;
        for (int j = 0; j < 3; j++) begin
            step();
            check("post_va", 32'(valid_activo), 32'h0);
            check("post_da", data_activo, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
